// File: rtl/error_display_ctrl.sv
// rtl/error_display_ctrl.sv - 4-digit error message / screen saver display controller.
// Optional build macro ERR_BLINK_EN: blank the error message on odd hold steps.
module error_display_ctrl #(
  parameter int REFRESH_DIV = 1000,
  parameter int STEP_DIV    = 50000,
  parameter int ERR_STEPS   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       saver_en,
  input  logic       err_req,
  input  logic [1:0] err_sel,
  input  logic       clear,
  output logic [3:0] seg_code,
  output logic [3:0] an_n,
  output logic [1:0] mode
);

  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int MAXS = (ERR_STEPS > 7) ? ERR_STEPS : 7;
  localparam int TW   = $clog2(MAXS + 1);

  // Message nibbles, one 16-bit word per select, digit3 in the top nibble.
  localparam logic [63:0] MSG = {16'hCBED, 16'h7AF8, 16'hCBD9, 16'hCBBE};

  typedef enum logic [1:0] {IDLE = 2'b00, SAVER = 2'b01, ERROR = 2'b10} state_t;

  state_t         state, nxt_state;
  logic [RW-1:0]  rcnt, nxt_rcnt;
  logic [1:0]     digit, nxt_digit;
  logic [SW-1:0]  scnt, nxt_scnt;
  logic [TW-1:0]  step, nxt_step;
  logic [1:0]     sel, nxt_sel;
  logic [3:0]     nxt_seg, nxt_an;
  logic           step_wrap, timeout, entry;

  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    nxt_rcnt  = rcnt + 1'b1;
    nxt_digit = digit;
    if (rcnt == RW'(REFRESH_DIV - 1)) begin
      nxt_rcnt  = '0;
      nxt_digit = digit + 1'b1;
    end

    step_wrap = (scnt == SW'(STEP_DIV - 1));
    timeout   = (state == ERROR) && step_wrap && (step == TW'(ERR_STEPS - 1));

    if (err_req) begin
      nxt_state = ERROR;
      nxt_sel   = err_sel;
    end else begin
      case (state)
        IDLE:    if (saver_en) nxt_state = SAVER;
        SAVER:   if (!saver_en) nxt_state = IDLE;
        ERROR:   if (clear || timeout) nxt_state = saver_en ? SAVER : IDLE;
        default: nxt_state = IDLE;
      endcase
    end

    // A retrigger counts as a fresh entry even though the state is unchanged.
    entry    = err_req || (nxt_state != state);
    nxt_scnt = scnt + 1'b1;
    nxt_step = step;
    if (entry) begin
      nxt_scnt = '0;
      nxt_step = '0;
    end else if (step_wrap) begin
      nxt_scnt = '0;
      nxt_step = (state == SAVER && step == TW'(6)) ? '0 : step + 1'b1;
    end

    nxt_seg = 4'h0;
    nxt_an  = 4'b1111;
    case (nxt_state)
      SAVER: begin
        nxt_seg = {1'b0, nxt_step[2:0]};
        nxt_an  = ~(4'b0001 << nxt_digit);
      end
      ERROR: begin
        nxt_seg = MSG[{nxt_sel, nxt_digit, 2'b00} +: 4];
        nxt_an  = ~(4'b0001 << nxt_digit);
`ifdef ERR_BLINK_EN
        if (nxt_step[0]) nxt_an = 4'b1111;
`else
        nxt_an  = ~(4'b0001 << nxt_digit);
`endif
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so mode tracks state on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rcnt     <= '0;
      digit    <= '0;
      scnt     <= '0;
      step     <= '0;
      sel      <= '0;
      seg_code <= 4'h0;
      an_n     <= 4'b1111;
      mode     <= 2'b00;
    end else begin
      state    <= nxt_state;
      rcnt     <= nxt_rcnt;
      digit    <= nxt_digit;
      scnt     <= nxt_scnt;
      step     <= nxt_step;
      sel      <= nxt_sel;
      seg_code <= nxt_seg;
      an_n     <= nxt_an;
      mode     <= nxt_state;
    end
  end

endmodule
